// File: rtl/dmem_mmio_ctrl_pkg.sv
// Shared address map, register offsets and CTRL/STATUS bit positions for dmem_mmio_ctrl.
package dmem_mmio_ctrl_pkg;

    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;

    // Word offsets (byte offset >> 2) inside the peripheral block
    localparam int unsigned REG_SEL_W = 3;
    localparam logic [REG_SEL_W-1:0] REG_CTRL    = 3'd0;
    localparam logic [REG_SEL_W-1:0] REG_COUNT   = 3'd1;
    localparam logic [REG_SEL_W-1:0] REG_COMPARE = 3'd2;
    localparam logic [REG_SEL_W-1:0] REG_STATUS  = 3'd3;
    localparam logic [REG_SEL_W-1:0] REG_GPIO    = 3'd4;

    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_AR        = 1;
    localparam int unsigned CTRL_IE        = 2;
    localparam int unsigned CTRL_PRESC_LSB = 8;
    localparam int unsigned PRESC_W        = 8;
    localparam int unsigned STATUS_MATCH   = 0;

    // Replace the byte lanes of old_v selected by be with the matching lanes of new_v
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Prescaled compare timer: CTRL/COUNT/COMPARE/STATUS registers and interrupt.
// Optional interrupt support is enabled with the DMEM_IRQ_EN macro.
module dmem_timer
    import dmem_mmio_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] din_i,
    input  logic        wr_ctrl_i,
    input  logic        wr_count_i,
    input  logic        wr_compare_i,
    input  logic        wr_status_i,
    output logic [31:0] ctrl_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic        irq_o
);

    logic               en_q, en_d;
    logic               ar_q, ar_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        compare_q, compare_d;
    logic               match_q, match_d;
    logic               ie_bit;
    logic               sw_timer_wr;
    logic               tick;
    logic               hit;
`ifdef DMEM_IRQ_EN
    logic               ie_q, ie_d;
    assign ie_bit = ie_q;
    assign irq_o  = match_q & ie_q;
`else
    assign ie_bit = 1'b0;
    assign irq_o  = 1'b0;
`endif

    // Software writes to CTRL/COUNT take precedence over the timer for this cycle
    assign sw_timer_wr = wr_ctrl_i | wr_count_i;
    assign tick        = en_q & (pcnt_q == presc_q) & ~sw_timer_wr;
    assign hit         = (count_q == compare_q);

    // Register read views
    always_comb begin
        ctrl_o                                = '0;
        ctrl_o[CTRL_EN]                       = en_q;
        ctrl_o[CTRL_AR]                       = ar_q;
        ctrl_o[CTRL_IE]                       = ie_bit;
        ctrl_o[CTRL_PRESC_LSB +: PRESC_W]     = presc_q;
        status_o                              = '0;
        status_o[STATUS_MATCH]                = match_q;
        count_o                               = count_q;
        compare_o                             = compare_q;
    end

    // Next-state: prescaler, tick handling, software writes
    always_comb begin
        en_d      = en_q;
        ar_d      = ar_q;
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = match_q;
`ifdef DMEM_IRQ_EN
        ie_d      = ie_q;
`endif

        if (sw_timer_wr || !en_q || tick) pcnt_d = '0;
        else                              pcnt_d = pcnt_q + PRESC_W'(1);

        // W1C comes first so a same-cycle match set wins
        if (wr_status_i && be_i[0] && din_i[STATUS_MATCH]) match_d = 1'b0;

        if (tick) begin
            if (hit) begin
                match_d = 1'b1;
                if (ar_q) count_d = '0;
                else      en_d    = 1'b0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_ctrl_i) begin
            if (be_i[0]) begin
                en_d = din_i[CTRL_EN];
                ar_d = din_i[CTRL_AR];
`ifdef DMEM_IRQ_EN
                ie_d = din_i[CTRL_IE];
`endif
            end
            if (be_i[1]) presc_d = din_i[CTRL_PRESC_LSB +: PRESC_W];
        end
        if (wr_count_i)   count_d   = be_merge(count_q, din_i, be_i);
        if (wr_compare_i) compare_d = be_merge(compare_q, din_i, be_i);
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            count_q   <= '0;
            compare_q <= '0;
            match_q   <= 1'b0;
`ifdef DMEM_IRQ_EN
            ie_q      <= 1'b0;
`endif
        end else begin
            en_q      <= en_d;
            ar_q      <= ar_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
`ifdef DMEM_IRQ_EN
            ie_q      <= ie_d;
`endif
        end
    end

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// Data-memory controller: byte-enabled word RAM, timer and GPIO behind an MMIO decode.
// Define DMEM_IRQ_EN to enable the timer interrupt and the CTRL.IE bit.
module dmem_mmio_ctrl
    import dmem_mmio_ctrl_pkg::*;
#(
    parameter int unsigned RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_din,
    input  logic [3:0]  dmem_be,
    input  logic        dmem_wren,
    output logic [31:0] dmem_dout,
    output logic [31:0] gpio_out,
    output logic        irq
);

    localparam int unsigned RAM_WORDS = 2 ** RAM_AW;

    logic [31:0]          ram_q [RAM_WORDS];
    logic [31:0]          gpio_q;
    logic [RAM_AW-1:0]    ram_idx;
    logic [29:0]          mmio_woff;
    logic [REG_SEL_W-1:0] reg_sel;
    logic                 is_ram;
    logic                 is_mmio;
    logic                 wr_en;
    logic                 wr_mmio;
    logic                 unused_addr_lsb;
    logic [31:0]          t_ctrl, t_count, t_compare, t_status;

    // Address decode on word addresses; byte offset bits are ignored
    assign unused_addr_lsb = ^dmem_addr[1:0];
    assign ram_idx   = dmem_addr[RAM_AW+1:2];
    assign is_ram    = (dmem_addr[31:16] == 16'd0);
    assign mmio_woff = dmem_addr[31:2] - MMIO_BASE[31:2];
    assign reg_sel   = mmio_woff[REG_SEL_W-1:0];
    assign is_mmio   = (mmio_woff[29:REG_SEL_W] == 27'd0) && (reg_sel <= REG_GPIO);
    assign wr_en     = dmem_wren & (|dmem_be);
    assign wr_mmio   = wr_en & is_mmio;

    dmem_timer u_timer (
        .clk_i        (clk),
        .rst_i        (rst),
        .be_i         (dmem_be),
        .din_i        (dmem_din),
        .wr_ctrl_i    (wr_mmio && (reg_sel == REG_CTRL)),
        .wr_count_i   (wr_mmio && (reg_sel == REG_COUNT)),
        .wr_compare_i (wr_mmio && (reg_sel == REG_COMPARE)),
        .wr_status_i  (wr_mmio && (reg_sel == REG_STATUS)),
        .ctrl_o       (t_ctrl),
        .count_o      (t_count),
        .compare_o    (t_compare),
        .status_o     (t_status),
        .irq_o        (irq)
    );

    // RAM byte-lane writes; contents survive reset but writes are blocked during it
    always_ff @(posedge clk) begin
        if (!rst && wr_en && is_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_be[b]) ram_q[ram_idx][8*b +: 8] <= dmem_din[8*b +: 8];
            end
        end
    end

    // GPIO output register
    always_ff @(posedge clk) begin
        if (rst)                                  gpio_q <= '0;
        else if (wr_mmio && (reg_sel == REG_GPIO)) gpio_q <= be_merge(gpio_q, dmem_din, dmem_be);
    end

    assign gpio_out = gpio_q;

    // Combinational load data; unmapped addresses read zero
    always_comb begin
        dmem_dout = '0;
        if (is_ram) begin
            dmem_dout = ram_q[ram_idx];
        end else if (is_mmio) begin
            case (reg_sel)
                REG_CTRL:    dmem_dout = t_ctrl;
                REG_COUNT:   dmem_dout = t_count;
                REG_COMPARE: dmem_dout = t_compare;
                REG_STATUS:  dmem_dout = t_status;
                REG_GPIO:    dmem_dout = gpio_q;
                default:     dmem_dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Scoreboard bench for dmem_mmio_ctrl: reads push expected data, a negedge monitor pops and compares.
module tb_dmem_mmio_ctrl;

    localparam logic [31:0] A_CTRL  = 32'hFFFF_0000;
    localparam logic [31:0] A_COUNT = 32'hFFFF_0004;
    localparam logic [31:0] A_CMP   = 32'hFFFF_0008;
    localparam logic [31:0] A_STAT  = 32'hFFFF_000C;
    localparam logic [31:0] A_GPIO  = 32'hFFFF_0010;
`ifdef DMEM_IRQ_EN
    localparam logic        IRQ_ON  = 1'b1;
    localparam logic [31:0] CTRL_T1 = 32'h0000_0007;
`else
    localparam logic        IRQ_ON  = 1'b0;
    localparam logic [31:0] CTRL_T1 = 32'h0000_0003;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [3:0]  dmem_be;
    logic        dmem_wren;
    logic [31:0] dmem_dout;
    logic [31:0] gpio_out;
    logic        irq;

    int          checks_n = 0;
    int          errors_n = 0;
    logic [31:0] exp_q[$];
    logic        rd_pend = 1'b0;
    string       rd_tag = "";

    dmem_mmio_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .dmem_addr (dmem_addr),
        .dmem_din  (dmem_din),
        .dmem_be   (dmem_be),
        .dmem_wren (dmem_wren),
        .dmem_dout (dmem_dout),
        .gpio_out  (gpio_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pop and compare load data in the middle of each read cycle
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() != 0) chk(rd_tag, dmem_dout, exp_q.pop_front());
            else                   chk({rd_tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        dmem_addr = a; dmem_din = d; dmem_be = b; dmem_wren = 1'b1;
        @(posedge clk); #1;
        dmem_wren = 1'b0; dmem_be = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        dmem_addr = a; dmem_wren = 1'b0;
        exp_q.push_back(e); rd_tag = tag; rd_pend = 1'b1;
        @(posedge clk); #1;
        rd_pend = 1'b0;
    endtask

    // Load of an address that is being stored in the same cycle
    task automatic wr_rd(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] e_old);
        dmem_addr = a; dmem_din = d; dmem_be = b; dmem_wren = 1'b1;
        exp_q.push_back(e_old); rd_tag = tag; rd_pend = 1'b1;
        @(posedge clk); #1;
        rd_pend = 1'b0; dmem_wren = 1'b0; dmem_be = 4'h0;
    endtask

    // Read plus irq check taken in the same state
    task automatic rd_irq(input string tag, input logic [31:0] a, input logic [31:0] e,
                          input logic e_irq);
        dmem_addr = a; dmem_wren = 1'b0;
        exp_q.push_back(e); rd_tag = tag; rd_pend = 1'b1;
        @(negedge clk); #1;
        chk({tag, "_irq"}, {31'd0, irq}, {31'd0, e_irq});
        @(posedge clk); #1;
        rd_pend = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dmem_addr = '0; dmem_din = '0; dmem_be = 4'h0; dmem_wren = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_gpio_out", gpio_out, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        rd("rst_ctrl",   A_CTRL,  32'd0);
        rd("rst_count",  A_COUNT, 32'd0);
        rd("rst_status", A_STAT,  32'd0);

        // RAM byte enables, aliasing and unmapped space
        wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        wr(32'h0000_0010, 32'h0000_00AA, 4'b0001);
        rd("ram_be",    32'h0000_0010, 32'hDEAD_BEAA);
        rd("ram_alias", 32'h0000_1010, 32'hDEAD_BEAA);
        rd("ram_lsb",   32'h0000_0013, 32'hDEAD_BEAA);
        wr(32'h0000_0000, 32'h0BAD_F00D, 4'hF);
        wr(32'h1234_0000, 32'hFFFF_FFFF, 4'hF);
        wr(32'hFFFF_0020, 32'hFFFF_FFFF, 4'hF);
        rd("unmap_lo",  32'h1234_0000, 32'd0);
        rd("unmap_hi",  32'hFFFF_0020, 32'd0);
        rd("ram0_kept", 32'h0000_0000, 32'h0BAD_F00D);
        rd("ram10_kept", 32'h0000_0010, 32'hDEAD_BEAA);
        wr_rd("rd_during_wr", 32'h0000_0010, 32'h1122_3344, 4'hF, 32'hDEAD_BEAA);
        rd("ram_new", 32'h0000_0010, 32'h1122_3344);
        wr(32'h0000_0010, 32'h5566_7788, 4'h0);
        rd("ram_be0_noop", 32'h0000_0010, 32'h1122_3344);

        // GPIO full and partial writes
        wr(A_GPIO, 32'h1234_5678, 4'hF);
        rd("gpio_rd", A_GPIO, 32'h1234_5678);
        chk("gpio_out", gpio_out, 32'h1234_5678);
        wr(A_GPIO, 32'hAABB_0000, 4'b1100);
        chk("gpio_out_be", gpio_out, 32'hAABB_5678);

        // Auto-reload timer, PRESC=0, COMPARE=3
        wr(A_CMP, 32'd3, 4'hF);
        wr(A_CTRL, 32'h0000_0007, 4'hF);
        rd("t1_ctrl", A_CTRL, CTRL_T1);
        for (int i = 1; i <= 4; i++) rd("t1_count", A_COUNT, (i == 4) ? 32'd0 : 32'(i));
        rd_irq("t1_match", A_STAT, 32'd1, IRQ_ON);
        wr(A_STAT, 32'd1, 4'hF);
        wr(A_CTRL, 32'd0, 4'hF);
        rd_irq("t1_w1c", A_STAT, 32'd0, 1'b0);

        // One-shot timer, PRESC=2, COMPARE=1
        wr(A_COUNT, 32'd0, 4'hF);
        wr(A_CMP, 32'd1, 4'hF);
        wr(A_CTRL, 32'h0000_0201, 4'hF);
        for (int i = 0; i < 6; i++) rd("t2_count", A_COUNT, (i < 3) ? 32'd0 : 32'd1);
        rd("t2_ctrl_en_clr", A_CTRL, 32'h0000_0200);
        rd_irq("t2_match", A_STAT, 32'd1, 1'b0);
        rd("t2_count_hold", A_COUNT, 32'd1);
        wr(A_STAT, 32'd1, 4'h1);
        rd("t2_w1c", A_STAT, 32'd0);

        // Software COUNT write against a tick, be=0 no-op, wrap
        wr(A_CMP, 32'h0000_FFFF, 4'hF);
        wr(A_CTRL, 32'h0000_0001, 4'hF);
        wr(A_COUNT, 32'h0000_0100, 4'hF);
        rd("t3_sw_wins", A_COUNT, 32'h0000_0100);
        rd("t3_next",    A_COUNT, 32'h0000_0101);
        wr(A_COUNT, 32'h0000_0000, 4'h0);
        rd("t3_be0",     A_COUNT, 32'h0000_0103);
        wr(A_COUNT, 32'hFFFF_FFFF, 4'hF);
        rd("t3_max",     A_COUNT, 32'hFFFF_FFFF);
        rd("t3_wrap",    A_COUNT, 32'h0000_0000);

        // Reset mid-count with a concurrent GPIO write
        rst = 1'b1; dmem_addr = A_GPIO; dmem_din = 32'hFFFF_FFFF; dmem_be = 4'hF; dmem_wren = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; dmem_wren = 1'b0; dmem_be = 4'h0;
        chk("mrst_gpio_out", gpio_out, 32'd0);
        chk("mrst_irq", {31'd0, irq}, 32'd0);
        rd("mrst_ctrl",   A_CTRL,  32'd0);
        rd("mrst_count",  A_COUNT, 32'd0);
        rd("mrst_cmp",    A_CMP,   32'd0);
        rd("mrst_status", A_STAT,  32'd0);
        rd("mrst_gpio",   A_GPIO,  32'd0);
        rd("mrst_ram10",  32'h0000_0010, 32'h1122_3344);
        rd("mrst_ram0",   32'h0000_0000, 32'h0BAD_F00D);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
